// File: rtl/filter_switch_ctrl.sv
// Click-free filter select controller for the highpass/lowpass core: fades the core output to silence,
// swaps the core filter select with a one-clock sync clear, flushes muted samples, then fades back up.
module filter_switch_ctrl #(
  parameter int         RAMP_SHIFT    = 5,
  parameter int         FLUSH_SAMPLES = 4,
  parameter logic [1:0] RESET_SEL     = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_en,
  input  logic [1:0]  filterReq,
  input  logic [15:0] filtIn,
  output logic [1:0]  filter,
  output logic        core_clr,
  output logic [15:0] audioOut,
  output logic        busy
);

  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = 16 + RAMP_SHIFT + 2;
  localparam int CW = $clog2(FLUSH_SAMPLES + 1);

  localparam logic [GW-1:0] G_FULL   = GW'(1 << RAMP_SHIFT);
  localparam logic [GW-1:0] G_ONE    = GW'(1);
  localparam logic [GW-1:0] G_ZERO   = '0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_SAMPLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_DOWN,
    ST_SWITCH,
    ST_FLUSH,
    ST_RAMP_UP
  } state_t;

  state_t      state_reg, state_next;
  logic [GW-1:0] g_reg, g_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]  filter_reg, filter_next;
  logic        clr_reg, clr_next;
  logic [15:0] audio_reg, audio_next;
  logic        req_change;

  logic signed [PW-1:0] in_ext;
  logic signed [PW-1:0] g_ext;

  assign req_change = (filterReq != filter_reg);

  // Direction checks are evaluated before terminal counts so a reversal always wins.
  always_comb begin
    state_next  = state_reg;
    g_next      = g_reg;
    cnt_next    = cnt_reg;
    filter_next = filter_reg;
    clr_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        g_next = G_FULL;
        if (sample_en && req_change) begin
          state_next = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (sample_en) begin
          if (!req_change) begin
            state_next = ST_RAMP_UP;
          end else if (g_reg <= G_ONE) begin
            g_next     = G_ZERO;
            state_next = ST_SWITCH;
          end else begin
            g_next = g_reg - G_ONE;
          end
        end
      end
      ST_SWITCH: begin
        g_next      = G_ZERO;
        filter_next = filterReq;
        clr_next    = 1'b1;
        cnt_next    = CNT_LOAD;
        state_next  = ST_FLUSH;
      end
      ST_FLUSH: begin
        g_next = G_ZERO;
        if (sample_en) begin
          if (cnt_reg <= CNT_ONE) begin
            cnt_next   = '0;
            state_next = ST_RAMP_UP;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end
      ST_RAMP_UP: begin
        if (sample_en) begin
          if (req_change) begin
            state_next = ST_RAMP_DOWN;
          end else if (g_reg >= (G_FULL - G_ONE)) begin
            g_next     = G_FULL;
            state_next = ST_IDLE;
          end else begin
            g_next = g_reg + G_ONE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        g_next     = G_FULL;
      end
    endcase
  end

  // Gain applied is the value held before this strobe's update; full scale and zero skip the multiplier.
  always_comb begin
    in_ext     = {{(PW-16){filtIn[15]}}, filtIn};
    g_ext      = {{(PW-GW){1'b0}}, g_reg};
    audio_next = audio_reg;
    if (sample_en) begin
      if (g_reg == G_FULL) begin
        audio_next = filtIn;
      end else if (g_reg == G_ZERO) begin
        audio_next = '0;
      end else begin
        audio_next = 16'((in_ext * g_ext) >>> RAMP_SHIFT);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      g_reg      <= G_FULL;
      cnt_reg    <= '0;
      filter_reg <= RESET_SEL;
      clr_reg    <= 1'b0;
      audio_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      g_reg      <= g_next;
      cnt_reg    <= cnt_next;
      filter_reg <= filter_next;
      clr_reg    <= clr_next;
      audio_reg  <= audio_next;
    end
  end

  assign filter   = filter_reg;
  assign core_clr = clr_reg;
  assign audioOut = audio_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_filter_switch_ctrl.sv
// Randomized and directed bench for filter_switch_ctrl against a gain/direction reference model.
module tb_filter_switch_ctrl;

  localparam int RAMP_SHIFT    = 5;
  localparam int FLUSH_SAMPLES = 4;
  localparam int FULL          = 1 << RAMP_SHIFT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [1:0]  filterReq = 2'd0;
  logic [15:0] filtIn = 16'd0;
  logic [1:0]  filter;
  logic        core_clr;
  logic [15:0] audioOut;
  logic        busy;

  filter_switch_ctrl #(
    .RAMP_SHIFT   (RAMP_SHIFT),
    .FLUSH_SAMPLES(FLUSH_SAMPLES),
    .RESET_SEL    (2'd0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sample_en(sample_en),
    .filterReq(filterReq),
    .filtIn   (filtIn),
    .filter   (filter),
    .core_clr (core_clr),
    .audioOut (audioOut),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int clr_seen = 0;

  // Reference model: gain, selected filter, fade direction (-1/0/+1), muted samples left, pending swap.
  int m_g, m_sel, m_dir, m_flush, m_audio;
  bit m_swp, m_clr;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scale(input int x, input int g);
    int p, q;
    if (g >= FULL) return x;
    if (g <= 0) return 0;
    p = x * g;
    q = p / FULL;
    if ((p % FULL) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit m_busy();
    return (m_dir != 0) || (m_flush > 0) || m_swp;
  endfunction

  task automatic model_reset();
    m_g = FULL; m_sel = 0; m_dir = 0; m_flush = 0; m_audio = 0; m_swp = 0; m_clr = 0;
  endtask

  task automatic model_step(input bit se, input int rq, input int x);
    int want;
    m_clr = 0;
    if (m_swp) begin
      m_sel = rq; m_clr = 1; m_flush = FLUSH_SAMPLES; m_swp = 0; m_g = 0;
    end else if (se) begin
      m_audio = scale(x, m_g);
      if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0) m_dir = 1;
      end else begin
        want = (rq != m_sel) ? -1 : 1;
        if (m_dir == 0) begin
          if (want < 0) m_dir = -1;
        end else if (want != m_dir) begin
          m_dir = want;
        end else if (m_dir < 0) begin
          m_g--;
          if (m_g <= 0) begin m_g = 0; m_dir = 0; m_swp = 1; end
        end else begin
          m_g++;
          if (m_g >= FULL) begin m_g = FULL; m_dir = 0; end
        end
      end
    end
  endtask

  task automatic tick(input bit se, input logic [1:0] rq, input logic [15:0] x);
    sample_en = se; filterReq = rq; filtIn = x;
    model_step(se, int'(rq), int'($signed(x)));
    @(negedge clk);
    if (core_clr) clr_seen++;
    check("audioOut", int'($signed(audioOut)), m_audio);
    check("filter", int'(filter), m_sel);
    check("core_clr", int'(core_clr), int'(m_clr));
    check("busy", int'(busy), int'(m_busy()));
  endtask

  task automatic strobe(input logic [1:0] rq, input logic [15:0] x, input int gap);
    tick(1'b1, rq, x);
    for (int i = 1; i < gap; i++) tick(1'b0, rq, x);
    n_strobe++;
    $display("strobe %0d req=%0d in=%0d -> audioOut=%0d filter=%0d busy=%0d", n_strobe, rq,
             $signed(x), $signed(audioOut), filter, busy);
  endtask

  task automatic run_until_idle(input logic [1:0] rq, input logic [15:0] x, input bit round_en,
                                input logic [15:0] round_x, input int round_exp, input string tag);
    bit hit;
    for (int i = 0; i < 200; i++) begin
      hit = round_en && (m_dir < 0) && (m_g == 1) && !m_swp && (m_flush == 0);
      strobe(rq, hit ? round_x : x, 3);
      if (hit) check(tag, int'($signed(audioOut)), round_exp);
      if (!m_busy()) return;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  function automatic logic [15:0] rand_sample();
    logic [15:0] corners [5];
    corners[0] = 16'h7FFF; corners[1] = 16'h8000; corners[2] = 16'hFFFF;
    corners[3] = 16'h0001; corners[4] = 16'h0000;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0;
    bit found;
    logic [1:0] rq;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_filter", int'(filter), 0);
    check("rst_audio", int'($signed(audioOut)), 0);
    check("rst_clr", int'(core_clr), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    // Steady state at full gain
    for (int i = 0; i < 4; i++) strobe(2'd0, 16'd16384, 3);
    check("steady_audio", int'($signed(audioOut)), 16384);
    check("steady_busy", int'(busy), 0);

    // Full switches with floor rounding probed at g=1
    c0 = clr_seen;
    run_until_idle(2'd3, 16'h7FFF, 1'b1, 16'h8000, -1024, "round_m32768");
    check("sw03_filter", int'(filter), 3);
    check("sw03_clr_pulses", clr_seen - c0, 1);
    run_until_idle(2'd0, 16'h7FFF, 1'b1, 16'hFFFF, -1, "round_m1");
    check("sw30_filter", int'(filter), 0);

    // Reversal after 10 ramp-down strobes
    c0 = clr_seen;
    strobe(2'd3, 16'h7FFF, 3);
    for (int i = 0; i < 10; i++) strobe(2'd3, 16'h7FFF, 3);
    strobe(2'd0, 16'h7FFF, 3);
    check("rev_turn", int'($signed(audioOut)), 22527);
    strobe(2'd0, 16'h7FFF, 3);
    check("rev_hold", int'($signed(audioOut)), 22527);
    strobe(2'd0, 16'h7FFF, 3);
    check("rev_up", int'($signed(audioOut)), 23551);
    run_until_idle(2'd0, 16'h7FFF, 1'b0, 16'h0000, 0, "none");
    check("rev_filter", int'(filter), 0);
    check("rev_no_clr", clr_seen - c0, 0);

    // Re-request during ramp-up at g=8
    c0 = clr_seen;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((m_dir > 0) && (m_g == 8) && (m_flush == 0)) begin
        found = 1'b1;
      end else if ((m_dir < 0) && (m_g == 1)) begin
        strobe(2'd3, 16'h0001, 3);
        check("round_p1", int'($signed(audioOut)), 0);
      end else begin
        strobe(2'd3, 16'h7FFF, 3);
      end
    end
    check("rereq_reach_g8", int'(found), 1);
    strobe(2'd1, 16'h7FFF, 3);
    check("rereq_g8", int'($signed(audioOut)), 8191);
    run_until_idle(2'd1, 16'h7FFF, 1'b0, 16'h0000, 0, "none");
    check("rereq_filter", int'(filter), 1);
    check("rereq_clr_pulses", clr_seen - c0, 2);

    // Asynchronous reset in the middle of a fade
    for (int i = 0; i < 6; i++) strobe(2'd2, 16'h7FFF, 3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_filter", int'(filter), 0);
    check("arst_audio", int'($signed(audioOut)), 0);
    check("arst_clr", int'(core_clr), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    filterReq = 2'd0;
    model_reset();

    // Randomized requests, samples and strobe spacing
    rq = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rq = 2'($urandom_range(0, 3));
      strobe(rq, rand_sample(), int'($urandom_range(2, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
